// File: rtl/execute_stage.sv
// EX pipeline stage: registered ADD/SUB/MOVE ALU with a two-beat SWAP,
// stall hold, flush and a valid/ready handshake toward ID/EX.
module execute_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       dest_a,
    input  logic [3:0]       dest_b,
    input  logic             reg_write,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_dest,
    output logic             out_reg_write,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [3:0]       out_dest_q, out_dest_d;
    logic             out_reg_write_q, out_reg_write_d;
    logic             out_zero_q, out_zero_d;
    logic             out_carry_q, out_carry_d;
    logic             out_ovf_q, out_ovf_d;
    logic [WIDTH-1:0] swap_a_q, swap_a_d;
    logic [3:0]       swap_dest_q, swap_dest_d;
    logic             swap_we_q, swap_we_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign in_ready = (state_q == IDLE) && !stall;

    // The extra top bit of diff is the unsigned borrow.
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path can infer a latch.
        state_d         = state_q;
        out_valid_d     = out_valid_q;
        out_result_d    = out_result_q;
        out_dest_d      = out_dest_q;
        out_reg_write_d = out_reg_write_q;
        out_zero_d      = out_zero_q;
        out_carry_d     = out_carry_q;
        out_ovf_d       = out_ovf_q;
        swap_a_d        = swap_a_q;
        swap_dest_d     = swap_dest_q;
        swap_we_d       = swap_we_q;

        if (flush) begin
            state_d         = IDLE;
            out_valid_d     = 1'b0;
            out_reg_write_d = 1'b0;
        end else if (stall) begin
            // Hold everything, including a pending SWAP beat 2.
        end else if (state_q == SWAP2) begin
            state_d         = IDLE;
            out_valid_d     = 1'b1;
            out_result_d    = swap_a_q;
            out_dest_d      = swap_dest_q;
            out_reg_write_d = swap_we_q;
            out_carry_d     = 1'b0;
            out_ovf_d       = 1'b0;
            out_zero_d      = (swap_a_q == '0);
        end else if (in_valid) begin
            out_valid_d     = 1'b1;
            out_dest_d      = dest_a;
            out_reg_write_d = reg_write;
            out_carry_d     = 1'b0;
            out_ovf_d       = 1'b0;
            unique case (alu_ctrl)
                3'b001: begin
                    out_result_d = diff[WIDTH-1:0];
                    out_carry_d  = diff[WIDTH];
                    out_ovf_d    = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                                   (diff[WIDTH-1] != op_a[WIDTH-1]);
                end
                3'b010: out_result_d = op_b;
                3'b011: begin
                    out_result_d = op_b;
                    state_d      = SWAP2;
                    swap_a_d     = op_a;
                    swap_dest_d  = dest_b;
                    swap_we_d    = reg_write;
                end
                default: begin
                    out_result_d = sum[WIDTH-1:0];
                    out_carry_d  = sum[WIDTH];
                    out_ovf_d    = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                   (sum[WIDTH-1] != op_a[WIDTH-1]);
                end
            endcase
            out_zero_d = (out_result_d == '0);
        end else begin
            out_valid_d     = 1'b0;
            out_reg_write_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_dest_q      <= '0;
            out_reg_write_q <= 1'b0;
            out_zero_q      <= 1'b0;
            out_carry_q     <= 1'b0;
            out_ovf_q       <= 1'b0;
            swap_a_q        <= '0;
            swap_dest_q     <= '0;
            swap_we_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_dest_q      <= out_dest_d;
            out_reg_write_q <= out_reg_write_d;
            out_zero_q      <= out_zero_d;
            out_carry_q     <= out_carry_d;
            out_ovf_q       <= out_ovf_d;
            swap_a_q        <= swap_a_d;
            swap_dest_q     <= swap_dest_d;
            swap_we_q       <= swap_we_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_dest      = out_dest_q;
    assign out_reg_write = out_reg_write_q;
    assign out_zero      = out_zero_q;
    assign out_carry     = out_carry_q;
    assign out_ovf       = out_ovf_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed corner cases followed by
// randomized traffic against a queue-based behavioural model.
module tb_execute_stage;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    alu_ctrl = '0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic [3:0]    dest_a = '0;
    logic [3:0]    dest_b = '0;
    logic          reg_write = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_result;
    logic [3:0]    out_dest;
    logic          out_reg_write;
    logic          out_zero;
    logic          out_carry;
    logic          out_ovf;

    execute_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .dest_a(dest_a),
        .dest_b(dest_b), .reg_write(reg_write), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_result(out_result), .out_dest(out_dest),
        .out_reg_write(out_reg_write), .out_zero(out_zero),
        .out_carry(out_carry), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected output registers plus a queue of beats still owed.
    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         we;
    } beat_t;

    beat_t        pend[$];
    logic         m_valid, m_we, m_zero, m_carry, m_ovf;
    logic [W-1:0] m_result;
    logic [3:0]   m_dest;

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_zero = 0; m_carry = 0; m_ovf = 0;
        m_result = '0; m_dest = '0;
        pend.delete();
    endtask

    task automatic model_step();
        int ua, ub, sa, sb, r, sr;
        ua = int'(op_a); ub = int'(op_b);
        sa = $signed(op_a); sb = $signed(op_b);
        if (flush) begin
            m_valid = 0; m_we = 0;
            pend.delete();
        end else if (stall) begin
            // outputs frozen
        end else if (pend.size() > 0) begin
            beat_t b;
            b = pend.pop_front();
            m_valid = 1; m_result = b.r; m_dest = b.d; m_we = b.we;
            m_carry = 0; m_ovf = 0; m_zero = (b.r == 0);
        end else if (in_valid) begin
            m_valid = 1; m_dest = dest_a; m_we = reg_write;
            m_carry = 0; m_ovf = 0;
            case (alu_ctrl)
                3'd1: begin
                    r = ua - ub; sr = sa - sb;
                    m_carry = (ua < ub);
                    m_ovf = (sr > 32767) || (sr < -32768);
                end
                3'd2: r = ub;
                3'd3: begin
                    beat_t b;
                    r = ub;
                    b.r = op_a; b.d = dest_b; b.we = reg_write;
                    pend.push_back(b);
                end
                default: begin
                    r = ua + ub; sr = sa + sb;
                    m_carry = (r > 65535);
                    m_ovf = (sr > 32767) || (sr < -32768);
                end
            endcase
            m_result = r[W-1:0];
            m_zero = (m_result == 0);
        end else begin
            m_valid = 0; m_we = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},  out_valid,     m_valid);
        check({tag, ".we"},     out_reg_write, m_we);
        check({tag, ".result"}, out_result,    m_result);
        check({tag, ".dest"},   out_dest,      m_dest);
        check({tag, ".zero"},   out_zero,      m_zero);
        check({tag, ".carry"},  out_carry,     m_carry);
        check({tag, ".ovf"},    out_ovf,       m_ovf);
    endtask

    // Inputs are driven at posedge+1; in_ready checked at negedge, outputs at posedge+1.
    task automatic cycle(input string tag);
        @(negedge clk);
        check({tag, ".in_ready"}, in_ready, (pend.size() == 0) && !stall);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] da, input logic [3:0] db,
                         input logic we, input logic st, input logic fl);
        in_valid = v; alu_ctrl = c; op_a = a; op_b = b; dest_a = da; dest_b = db;
        reg_write = we; stall = st; flush = fl;
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset.in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // ADD wrap to zero with carry
        drive(1, 3'd0, 16'hFFFF, 16'h0001, 4'd1, 4'd0, 1, 0, 0);
        cycle("add");
        check("add.result_k", out_result, 16'h0000);
        check("add.zero_k",   out_zero,   1'b1);
        check("add.carry_k",  out_carry,  1'b1);
        check("add.ovf_k",    out_ovf,    1'b0);

        // SUB signed overflow
        drive(1, 3'd1, 16'h8000, 16'h0001, 4'd2, 4'd0, 1, 0, 0);
        cycle("sub");
        check("sub.result_k", out_result, 16'h7FFF);
        check("sub.ovf_k",    out_ovf,    1'b1);
        check("sub.carry_k",  out_carry,  1'b0);

        // SWAP; inputs changed during SWAP2 must be ignored
        drive(1, 3'd3, 16'h1111, 16'h2222, 4'd3, 4'd5, 1, 0, 0);
        cycle("swap_b1");
        check("swap_b1.result_k", out_result, 16'h2222);
        check("swap_b1.dest_k",   out_dest,   4'd3);
        drive(1, 3'd3, 16'hDEAD, 16'hBEEF, 4'd7, 4'd9, 1, 0, 0);
        cycle("swap_b2");
        check("swap_b2.result_k", out_result, 16'h1111);
        check("swap_b2.dest_k",   out_dest,   4'd5);
        drive(0, 3'd0, 16'h0, 16'h0, 4'd0, 4'd0, 0, 0, 0);
        cycle("idle");

        // SWAP with a 3-cycle stall in SWAP2
        drive(1, 3'd3, 16'h1111, 16'h2222, 4'd3, 4'd5, 1, 0, 0);
        cycle("sst_b1");
        drive(1, 3'd0, 16'h4444, 16'h5555, 4'd6, 4'd8, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("sst_hold");
            check("sst_hold.result_k", out_result, 16'h2222);
        end
        drive(0, 3'd0, 16'h0, 16'h0, 4'd0, 4'd0, 0, 0, 0);
        cycle("sst_b2");
        check("sst_b2.result_k", out_result, 16'h1111);
        check("sst_b2.dest_k",   out_dest,   4'd5);

        // Flush in SWAP2 drops beat 2
        drive(1, 3'd3, 16'h1111, 16'h2222, 4'd3, 4'd5, 1, 0, 0);
        cycle("sfl_b1");
        drive(1, 3'd0, 16'h0, 16'h0, 4'd0, 4'd0, 1, 1, 1);
        cycle("sfl_flush");
        check("sfl_flush.valid_k", out_valid, 1'b0);
        check("sfl_flush.we_k",    out_reg_write, 1'b0);
        drive(0, 3'd0, 16'h0, 16'h0, 4'd0, 4'd0, 0, 0, 0);
        cycle("sfl_after");
        check("sfl_after.valid_k", out_valid, 1'b0);

        // Asynchronous reset mid-SWAP, then a MOVE
        drive(1, 3'd3, 16'h1111, 16'h2222, 4'd3, 4'd5, 1, 0, 0);
        cycle("srst_b1");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("srst_async");
        drive(0, 3'd0, 16'h0, 16'h0, 4'd0, 4'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_outputs("srst_held");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 3'd2, 16'h0000, 16'h00AB, 4'd4, 4'd0, 1, 0, 0);
        #1;
        check("srst_rel.in_ready", in_ready, 1'b1);
        @(posedge clk);
        model_step();
        #1;
        check_outputs("srst_move");
        check("srst_move.result_k", out_result, 16'h00AB);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
            if (n % 8 == 0) op_b = (n % 16 == 0) ? op_a : 16'h0000;
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the datapath width in bits.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-004 SHALL have port in_valid, input, 1, ID/EX holds an instruction to execute.
REQ-005 SHALL have port in_ready, output, 1, stage accepts an instruction this cycle.
REQ-006 SHALL have port alu_ctrl, input, 3, ALU operation select: 000 ADD, 001 SUB, 010 MOVE, 011 SWAP.
REQ-007 SHALL have port op_a, input, WIDTH, first operand.
REQ-008 SHALL have port op_b, input, WIDTH, second operand.
REQ-009 SHALL have port dest_a, input, 4, primary destination register.
REQ-010 SHALL have port dest_b, input, 4, SWAP second destination register.
REQ-011 SHALL have port reg_write, input, 1, instruction writes the register file.
REQ-012 SHALL have port stall, input, 1, downstream hazard hold.
REQ-013 SHALL have port flush, input, 1, discard in-flight work.
REQ-014 SHALL have port out_valid, output, 1, EX/MEM result valid.
REQ-015 SHALL have port out_result, output, WIDTH, registered ALU result.
REQ-016 SHALL have port out_dest, output, 4, destination of out_result.
REQ-017 SHALL have port out_reg_write, output, 1, registered write enable, 0 whenever out_valid=0.
REQ-018 SHALL have port out_zero, output, 1, out_result == 0.
REQ-019 SHALL have port out_carry, output, 1, carry/borrow from ADD/SUB.
REQ-020 SHALL have port out_ovf, output, 1, signed overflow from ADD/SUB.

Function
REQ-021 SHALL implement FSM states IDLE and SWAP2; IDLE accepts, SWAP2 issues the second SWAP beat.
REQ-022 SHALL drive in_ready = 1 only in IDLE with stall=0.
REQ-023 SHALL accept on in_valid & in_ready; results appear on outputs one cycle after acceptance (latency 1).
REQ-024 SHALL compute ADD as op_a+op_b mod 2^WIDTH, out_carry = bit WIDTH of the sum, out_ovf = signed overflow.
REQ-025 SHALL compute SUB as op_a-op_b mod 2^WIDTH, out_carry = 1 when op_a < op_b unsigned (borrow), out_ovf = signed overflow.
REQ-026 SHALL compute MOVE as out_result = op_b, out_dest = dest_a, with out_carry = out_ovf = 0.
REQ-027 SHALL handle SWAP in two beats, with out_carry = out_ovf = 0 on both:
- beat 1: out_result = op_b, out_dest = dest_a, then go to SWAP2 and latch op_a and dest_b internally;
- beat 2: out_result = latched op_a, out_dest = dest_b, then return to IDLE.
REQ-028 SHALL treat unused alu_ctrl codes (1xx) as ADD.
REQ-029 SHALL set out_zero from the registered out_result on every valid beat.
REQ-030 SHALL hold all outputs and the FSM state unchanged while stall=1, including in SWAP2.
REQ-031 SHALL deassert out_valid when in IDLE with no acceptance and stall=0.
REQ-032 SHALL give flush priority over stall and acceptance: next cycle out_valid = 0, out_reg_write = 0, state = IDLE, and any pending SWAP beat 2 is dropped.
REQ-033 SHALL keep SWAP beat 2 from using new op_a/dest_b inputs; input changes during SWAP2 have no effect.

Reset
REQ-034 SHALL, on rst_n low, immediately force state IDLE and set out_valid, out_reg_write, out_result, out_dest, out_zero, out_carry and out_ovf to 0.
REQ-035 SHALL abort any SWAP in progress on reset and drop its second beat.
REQ-036 SHALL drive in_ready = 1 on the first cycle after rst_n deasserts when stall = 0.

Verification
REQ-037 SHALL cover ADD: op_a=16'hFFFF, op_b=16'h0001, accept -> next cycle out_result=0000, out_zero=1, out_carry=1, out_ovf=0.
REQ-038 SHALL cover SUB: op_a=16'h8000, op_b=16'h0001 -> out_result=7FFF, out_ovf=1, out_carry=0.
REQ-039 SHALL cover SWAP: op_a=0x1111, op_b=0x2222, dest_a=3, dest_b=5 -> beat 1 result 2222 to dest 3, beat 2 result 1111 to dest 5, in_ready=0 during SWAP2.
REQ-040 SHALL cover SWAP with stall=1 for 3 cycles in SWAP2 -> outputs frozen; beat 2 appears one cycle after stall drops.
REQ-041 SHALL cover flush asserted in SWAP2 -> next cycle out_valid=0, state IDLE, and no dest_b write occurs.
REQ-042 SHALL cover rst_n asserted mid-SWAP -> all outputs 0 immediately; after release, a MOVE op_b=0x00AB gives out_result=00AB.
